// File: rtl/btb_update_controller.sv
// BTB update sequencer: buffers stage-3 branch outcomes in a small FIFO
// and runs full-table invalidation sweeps on flush requests.
module btb_update_controller #(
    parameter int BW_ADDR     = 24,
    parameter int BTB_ENTRIES = 64,
    parameter int FIFO_DEPTH  = 4,
    parameter int BW_DROP     = 16
) (
    input  logic                           clock_i,
    input  logic                           resetn_i,
    input  logic                           res_valid_i,
    input  logic [BW_ADDR-1:0]             res_pc_i,
    input  logic [BW_ADDR-1:0]             res_target_i,
    input  logic                           res_mispredict_i,
    input  logic                           stall_i,
    input  logic                           flush_i,
    input  logic                           wr_ready_i,
    output logic                           wr_valid_o,
    output logic [BW_ADDR-1:0]             wr_pc_o,
    output logic [BW_ADDR-1:0]             wr_target_o,
    output logic                           wr_mispredict_o,
    output logic                           inv_valid_o,
    output logic [$clog2(BTB_ENTRIES)-1:0] inv_index_o,
    output logic                           busy_o,
    output logic [BW_DROP-1:0]             drop_count_o
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    typedef struct packed {
        logic [BW_ADDR-1:0] pc;
        logic [BW_ADDR-1:0] target;
        logic               mispredict;
    } upd_t;

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   idx_q;
    upd_t               mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [BW_ADDR-1:0] last_pc_q;
    logic               last_valid_q;
    logic [BW_DROP-1:0] drop_q;

    logic in_idle;
    logic flush_start;
    logic sweep_done;
    logic dup;
    logic accept;
    logic full;
    logic empty;
    logic pop;
    logic push;
    logic drop;

    assign in_idle     = (state_q == IDLE);
    assign flush_start = in_idle && flush_i;
    assign sweep_done  = (state_q == FLUSH)
                      && (idx_q == IDX_W'(BTB_ENTRIES - 1));

    // A stalled stage 3 re-reports the same branch; suppress the repeat.
    assign dup    = stall_i && last_valid_q && (res_pc_i == last_pc_q);
    assign accept = in_idle && res_valid_i && !flush_i && !dup;

    assign full  = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign empty = (cnt_q == '0);
    assign pop   = wr_valid_o && wr_ready_i;
    assign push  = accept && (!full || pop);
    assign drop  = accept && full && !pop;

    assign wr_valid_o      = !empty && in_idle;
    assign wr_pc_o         = mem_q[rd_ptr_q].pc;
    assign wr_target_o     = mem_q[rd_ptr_q].target;
    assign wr_mispredict_o = mem_q[rd_ptr_q].mispredict;
    assign inv_valid_o     = (state_q == FLUSH);
    assign inv_index_o     = idx_q;
    assign busy_o          = (state_q == FLUSH) || !empty;
    assign drop_count_o    = drop_q;

    // State register.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Next-state: enter sweep on flush, leave after the last index.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (flush_i)    state_d = FLUSH;
            FLUSH:   if (sweep_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sweep index walks the table once, then parks at zero.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            idx_q <= '0;
        end else if (state_q == FLUSH) begin
            idx_q <= sweep_done ? '0 : idx_q + 1'b1;
        end
    end

    // Pending-update FIFO; a flush discards everything queued.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_start) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= '{pc:         res_pc_i,
                                     target:     res_target_i,
                                     mispredict: res_mispredict_i};
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Remember the last accepted PC for duplicate suppression.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            last_pc_q    <= '0;
            last_valid_q <= 1'b0;
        end else if ((state_q == FLUSH) || flush_start) begin
            last_valid_q <= 1'b0;
        end else if (accept) begin
            last_pc_q    <= res_pc_i;
            last_valid_q <= 1'b1;
        end else if (!stall_i && !res_valid_i) begin
            last_valid_q <= 1'b0;
        end
    end

    // Saturating count of updates lost to a full FIFO.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            drop_q <= '0;
        end else if (drop && (drop_q != '1)) begin
            drop_q <= drop_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_btb_update_controller.sv
// Scoreboard bench for btb_update_controller.
// Expected writes are queued at stimulus time and popped on each handshake.
module tb_btb_update_controller;

    logic        clock_i = 1'b0;
    logic        resetn_i;
    logic        res_valid_i;
    logic [23:0] res_pc_i;
    logic [23:0] res_target_i;
    logic        res_mispredict_i;
    logic        stall_i;
    logic        flush_i;
    logic        wr_ready_i;
    logic        wr_valid_o;
    logic [23:0] wr_pc_o;
    logic [23:0] wr_target_o;
    logic        wr_mispredict_o;
    logic        inv_valid_o;
    logic [5:0]  inv_index_o;
    logic        busy_o;
    logic [15:0] drop_count_o;

    btb_update_controller #(
        .BW_ADDR(24), .BTB_ENTRIES(64), .FIFO_DEPTH(4), .BW_DROP(16)
    ) dut (
        .clock_i(clock_i), .resetn_i(resetn_i),
        .res_valid_i(res_valid_i), .res_pc_i(res_pc_i),
        .res_target_i(res_target_i), .res_mispredict_i(res_mispredict_i),
        .stall_i(stall_i), .flush_i(flush_i), .wr_ready_i(wr_ready_i),
        .wr_valid_o(wr_valid_o), .wr_pc_o(wr_pc_o),
        .wr_target_o(wr_target_o), .wr_mispredict_o(wr_mispredict_o),
        .inv_valid_o(inv_valid_o), .inv_index_o(inv_index_o),
        .busy_o(busy_o), .drop_count_o(drop_count_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic [23:0] pc;
        logic [23:0] tgt;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   n_wr     = 0;
    int   n0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock_i);
        #1;
    endtask

    task automatic drive(input logic [23:0] pc, input logic [23:0] tgt,
                         input logic mis, input bit expect_wr);
        res_valid_i      = 1'b1;
        res_pc_i         = pc;
        res_target_i     = tgt;
        res_mispredict_i = mis;
        if (expect_wr) sb.push_back('{pc: pc, tgt: tgt, mis: mis});
    endtask

    task automatic sweep(input string tag, input int pulse_at);
        for (int i = 0; i < 64; i++) begin
            @(negedge clock_i);
            check({tag, "_inv_v"}, inv_valid_o, 1);
            check({tag, "_inv_i"}, inv_index_o, i);
            check({tag, "_wr_v"}, wr_valid_o, 0);
            flush_i = (i == pulse_at);
        end
        @(negedge clock_i);
        flush_i = 1'b0;
        check({tag, "_end_inv"}, inv_valid_o, 0);
        check({tag, "_end_busy"}, busy_o, 0);
        check({tag, "_end_wr"}, wr_valid_o, 0);
    endtask

    // Handshake monitor: every accepted write must match the queue head.
    always @(negedge clock_i) begin
        if (resetn_i && wr_valid_o && wr_ready_i) begin
            n_wr++;
            check("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("wr_pc", wr_pc_o, mon_e.pc);
                check("wr_target", wr_target_o, mon_e.tgt);
                check("wr_mis", wr_mispredict_o, mon_e.mis);
            end
        end
    end

    initial begin
        resetn_i = 1'b0;
        res_valid_i = 1'b0;
        res_pc_i = '0;
        res_target_i = '0;
        res_mispredict_i = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        wr_ready_i = 1'b0;
        #12;
        check("rst_wr_v", wr_valid_o, 0);
        check("rst_wr_pc", wr_pc_o, 0);
        check("rst_wr_tgt", wr_target_o, 0);
        check("rst_wr_mis", wr_mispredict_o, 0);
        check("rst_inv_v", inv_valid_o, 0);
        check("rst_inv_i", inv_index_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_drop", drop_count_o, 0);
        resetn_i = 1'b1;
        cyc();

        // Three separated pulses, ready always high.
        wr_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(24'(16 * (i + 1)), 24'(16 * (i + 1) + 256), i[0], 1'b1);
            @(negedge clock_i);
            check("t1_pre", wr_valid_o, 0);
            cyc();
            res_valid_i = 1'b0;
            @(negedge clock_i);
            check("t1_lat1", wr_valid_o, 1);
            cyc();
        end
        cyc();
        @(negedge clock_i);
        check("t1_busy", busy_o, 0);
        check("t1_drop", drop_count_o, 0);
        check("t1_sb", sb.size(), 0);
        cyc();

        // Stalled duplicate reports collapse to one update.
        n0 = n_wr;
        stall_i = 1'b1;
        drive(24'h44, 24'h444, 1'b0, 1'b1);
        repeat (5) cyc();
        stall_i = 1'b0;
        res_valid_i = 1'b0;
        cyc();
        drive(24'h44, 24'h448, 1'b1, 1'b1);
        cyc();
        res_valid_i = 1'b0;
        repeat (3) cyc();
        @(negedge clock_i);
        check("t2_count", n_wr - n0, 2);
        check("t2_sb", sb.size(), 0);
        cyc();

        // Overflow: six updates into a depth-4 FIFO with no ready.
        wr_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(24'h100 + 24'(i), 24'h500 + 24'(i), i[0], i < 4);
            cyc();
        end
        res_valid_i = 1'b0;
        @(negedge clock_i);
        check("t3_drop", drop_count_o, 2);
        check("t3_busy", busy_o, 1);
        check("t3_head", wr_pc_o, 24'h100);
        cyc();
        wr_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock_i);
            check("t3_drain", wr_valid_o, 1);
            cyc();
        end
        @(negedge clock_i);
        check("t3_empty", wr_valid_o, 0);
        check("t3_sb", sb.size(), 0);
        cyc();

        // Flush discards three queued updates, then sweeps 64 entries.
        wr_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(24'h600 + 24'(i), 24'h700 + 24'(i), 1'b0, 1'b0);
            cyc();
        end
        res_valid_i = 1'b0;
        n0 = n_wr;
        flush_i = 1'b1;
        @(negedge clock_i);
        check("t4_held", wr_valid_o, 1);
        cyc();
        flush_i = 1'b0;
        wr_ready_i = 1'b1;
        sweep("t4", -1);
        check("t4_nowr", n_wr - n0, 0);
        check("t4_drop", drop_count_o, 2);
        cyc();

        // Flush with a same-cycle update, re-flush at index 10 ignored.
        drive(24'h200, 24'h210, 1'b0, 1'b0);
        flush_i = 1'b1;
        cyc();
        res_valid_i = 1'b0;
        flush_i = 1'b0;
        sweep("t5", 10);
        cyc();
        @(negedge clock_i);
        check("t5_nowr", n_wr - n0, 0);
        check("t5_drop", drop_count_o, 2);
        check("t5_busy", busy_o, 0);
        cyc();

        // Reset mid-sweep aborts to reset values.
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        begin
            int k;
            k = 0;
            while (inv_index_o != 6'd20 && k < 200) begin
                @(negedge clock_i);
                k++;
            end
        end
        check("t6_reach", inv_index_o, 20);
        resetn_i = 1'b0;
        #1;
        check("t6_inv_v", inv_valid_o, 0);
        check("t6_inv_i", inv_index_o, 0);
        check("t6_busy", busy_o, 0);
        check("t6_drop", drop_count_o, 0);
        check("t6_wr_v", wr_valid_o, 0);
        #20;
        resetn_i = 1'b1;
        cyc();
        drive(24'h300, 24'h310, 1'b1, 1'b1);
        @(negedge clock_i);
        check("t6_pre", wr_valid_o, 0);
        cyc();
        res_valid_i = 1'b0;
        @(negedge clock_i);
        check("t6_lat1", wr_valid_o, 1);
        check("t6_inv", inv_valid_o, 0);
        cyc();
        cyc();
        @(negedge clock_i);
        check("final_sb", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btb_update_controller.md
Name: btb_update_controller

Overview:
- Sequences all writes into the branch target buffer's single update port.
- Buffers branch outcomes resolved at stage 3 in a small FIFO and drops duplicate reports of a stalled branch.
- Presents updates one at a time over a valid/ready handshake.
- Runs a full-table invalidation sweep on a flush request (context switch, fence.i), with priority over pending updates.

Parameters:
- BW_ADDR, 24, word-address width of PCs and targets.
- BTB_ENTRIES, 64, number of BTB entries to walk during a flush sweep.
- FIFO_DEPTH, 4, number of pending-update slots; must be a power of two and at least 2.
- BW_DROP, 16, width of the saturating overflow-drop counter.

Ports:
- clock_i  in  1  single core clock; all state updates on the rising edge.
- resetn_i  in  1  asynchronous, active-low reset.
- res_valid_i  in  1  stage-3 resolved branch/JAL is present this cycle.
- res_pc_i  in  BW_ADDR  word address of the resolved branch.
- res_target_i  in  BW_ADDR  computed jump destination.
- res_mispredict_i  in  1  front-end prediction for this branch was wrong.
- stall_i  in  1  pipeline stalled; stage 3 is holding the same instruction.
- flush_i  in  1  request a full BTB invalidation.
- wr_ready_i  in  1  BTB accepts the presented update this cycle.
- wr_valid_o  out  1  update presented.
- wr_pc_o  out  BW_ADDR  update PC.
- wr_target_o  out  BW_ADDR  update target.
- wr_mispredict_o  out  1  update mispredict flag.
- inv_valid_o  out  1  invalidate the entry at inv_index_o this cycle.
- inv_index_o  out  clog2(BTB_ENTRIES)  entry being invalidated.
- busy_o  out  1  high while in FLUSH or while the FIFO is non-empty.
- drop_count_o  out  BW_DROP  number of updates lost to a full FIFO; saturates.

Behaviour:
- Reset (asynchronous, resetn_i low):
  - State goes to IDLE; FIFO is emptied.
  - last_pc and last_valid are cleared.
  - All outputs are 0.
- FSM has two states: IDLE and FLUSH.
  - IDLE -> FLUSH when flush_i=1.
  - FLUSH -> IDLE after inv_index_o reaches BTB_ENTRIES-1 is issued.
  - flush_i while already in FLUSH is ignored; the sweep does not restart.
- Accept rule, evaluated in IDLE only:
  - An update is accepted when res_valid_i=1, flush_i=0, and NOT (stall_i=1 AND last_valid=1 AND res_pc_i==last_pc).
  - On accept: last_pc is set to res_pc_i and last_valid is set to 1.
  - last_valid is cleared on any cycle with stall_i=0 and res_valid_i=0.
- FIFO:
  - An accepted update is pushed at the clock edge and is visible on wr_* the next cycle (latency 1).
  - wr_valid_o = FIFO not empty AND state is IDLE. wr_* are driven directly from the FIFO head.
  - Pop occurs on wr_valid_o & wr_ready_i.
  - Push and pop in the same cycle are allowed when full (net occupancy unchanged, no drop) and when empty with a bypass-free path (the new entry appears next cycle).
  - If the FIFO is full with no pop, the new update is dropped and drop_count_o increments, saturating at all-ones.
  - Read and write pointers wrap modulo FIFO_DEPTH. Occupancy uses a separate count of clog2(FIFO_DEPTH)+1 bits.
- Flush:
  - On the IDLE->FLUSH edge the FIFO is emptied, discarding pending updates. A wr_valid_o held without wr_ready_i is abandoned.
  - In FLUSH: inv_valid_o=1 every cycle, inv_index_o counts 0..BTB_ENTRIES-1, one per cycle, with no handshake. The sweep lasts exactly BTB_ENTRIES cycles.
  - In FLUSH: wr_valid_o=0, all res_valid_i are ignored and not counted, and last_valid is cleared.
  - flush_i and res_valid_i in the same IDLE cycle: flush wins and the update is discarded without counting.
- busy_o is combinational from state and FIFO count.
- Reset asserted mid-sweep or mid-handshake aborts immediately to reset values. No partial state survives.

Test Plan:
- Reset then three res_valid_i pulses (pc 0x10, 0x20, 0x30) with wr_ready_i=1:
  - wr_valid_o rises one cycle after each pulse.
  - wr_pc_o shows 0x10, 0x20, 0x30 in order.
  - busy_o returns to 0; drop_count_o=0.
- stall_i=1 with res_valid_i held 5 cycles at pc 0x44:
  - Exactly one update is pushed.
  - Releasing the stall and presenting pc 0x44 again after a res_valid_i=0 cycle pushes a second update.
- wr_ready_i=0 and six distinct updates:
  - The first four are queued; drop_count_o=2.
  - Raising wr_ready_i then drains 4 entries, one per cycle, in order.
- flush_i with 3 entries queued, BTB_ENTRIES=64:
  - Pending updates are discarded.
  - inv_valid_o is high 64 consecutive cycles with inv_index_o 0..63.
  - wr_valid_o stays 0 throughout; then IDLE with busy_o=0.
- flush_i and res_valid_i in the same cycle, plus flush_i pulsed again at sweep index 10:
  - The update is discarded and not counted.
  - The sweep still ends after 64 cycles total.
- resetn_i pulsed low at inv_index_o=20:
  - Outputs go to 0 asynchronously.
  - After release, a new update appears on wr_valid_o one cycle after acceptance.
